// File: rtl/phaser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phaser_pkg
//  Purpose  : Shared types, Q1.15 constants and saturation helper for the
//             phaser scheduler. sat16 is used only when PHASER_SAT_EN is
//             defined.
//  Revision : 1.0 - initial release
// ============================================================================
package phaser_pkg;

   localparam int Q15_W  = 16;
   localparam int PROD_W = 32;

   localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7FFF;
   localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Clamp a 17-bit signed sum into the Q1.15 range.
   function automatic logic signed [Q15_W-1:0] sat16(input logic signed [Q15_W:0] v);
      if (v > 17'sd32767) begin
         return Q15_MAX;
      end else if (v < -17'sd32768) begin
         return Q15_MIN;
      end else begin
         return Q15_W'(v);
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/phaser_stage_alu.sv
`default_nettype none
// ============================================================================
//  Module   : phaser_stage_alu
//  Purpose  : Combinational first-order allpass step shared by every stage.
//             fb = (coef*d) >>> 15 (truncated to 16 bits), y = d - fb,
//             d_next = x + fb. Sums saturate when PHASER_SAT_EN is defined,
//             otherwise they wrap modulo 2^16.
//  Revision : 1.0 - initial release
// ============================================================================
module phaser_stage_alu
   import phaser_pkg::*;
(
   input  logic [Q15_W-1:0] x,
   input  logic [Q15_W-1:0] d,
   input  logic [Q15_W-1:0] coef,
   output logic [Q15_W-1:0] y,
   output logic [Q15_W-1:0] d_next
);

   logic signed [PROD_W-1:0] prod;
   logic signed [Q15_W-1:0]  fb;
   logic signed [Q15_W:0]    sum_y;
   logic signed [Q15_W:0]    sum_d;

   // Single Q1.15 multiply, then both sums carried one bit wide to expose overflow.
   always_comb begin
      prod  = $signed(coef) * $signed(d);
      fb    = Q15_W'(prod >>> (Q15_W - 1));
      sum_y = (Q15_W+1)'($signed(d)) - (Q15_W+1)'(fb);
      sum_d = (Q15_W+1)'($signed(x)) + (Q15_W+1)'(fb);
`ifdef PHASER_SAT_EN
      y      = sat16(sum_y);
      d_next = sat16(sum_d);
`else
      y      = Q15_W'(sum_y);
      d_next = Q15_W'(sum_d);
`endif
   end

endmodule
`default_nettype wire

// File: rtl/phaser_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : phaser_scheduler
//  Purpose  : Time-multiplexed multi-stage phaser. Each accepted sample is
//             walked through N_STAGES allpass stages, one per clock, using a
//             single shared stage ALU and a per-stage delay register file.
//             A triangle LFO sweeps the coefficient once per accepted sample.
//             Optional macro PHASER_SAT_EN selects saturating stage sums.
//  Revision : 1.0 - initial release
// ============================================================================
module phaser_scheduler
   import phaser_pkg::*;
#(
   parameter int                      N_STAGES = 4,
   parameter logic signed [Q15_W-1:0] COEF_MIN = 16'sd0,
   parameter logic signed [Q15_W-1:0] COEF_MAX = 16'sd26214,
   parameter logic [Q15_W-1:0]        LFO_STEP = 16'd64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Q15_W-1:0] in_sample,
   input  logic             bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Q15_W-1:0] out_sample,
   output logic [Q15_W-1:0] lfo_coef
);

   localparam int             K_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_STAGES - 1);

   // LFO arithmetic is done two bits wider so step overshoot never wraps.
   localparam logic signed [Q15_W+1:0] MAX_EXT  = (Q15_W+2)'(COEF_MAX);
   localparam logic signed [Q15_W+1:0] MIN_EXT  = (Q15_W+2)'(COEF_MIN);
   localparam logic signed [Q15_W+1:0] STEP_EXT = $signed({2'b00, LFO_STEP});

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [Q15_W-1:0] x_q, x_d;
   logic [Q15_W-1:0] coef_q, coef_d;
   logic             byp_q, byp_d;
   logic [Q15_W-1:0] lfo_q, lfo_d;
   logic             dir_down_q, dir_down_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [Q15_W-1:0] out_sample_q, out_sample_d;
   logic [Q15_W-1:0] d_q [N_STAGES];
   logic [Q15_W-1:0] d_d [N_STAGES];

   logic [Q15_W-1:0]        alu_d_in;
   logic [Q15_W-1:0]        alu_y;
   logic [Q15_W-1:0]        alu_d_next;
   logic signed [Q15_W+1:0] lfo_up;
   logic signed [Q15_W+1:0] lfo_dn;

   assign alu_d_in = d_q[k_q];
   assign lfo_up   = (Q15_W+2)'($signed(lfo_q)) + STEP_EXT;
   assign lfo_dn   = (Q15_W+2)'($signed(lfo_q)) - STEP_EXT;

   phaser_stage_alu u_alu (
      .x      (x_q),
      .coef   (coef_q),
      .d      (alu_d_in),
      .y      (alu_y),
      .d_next (alu_d_next)
   );

   // Next-state logic: accept, per-stage sequencing, output handshake and LFO sweep.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      x_d          = x_q;
      coef_d       = coef_q;
      byp_d        = byp_q;
      lfo_d        = lfo_q;
      dir_down_d   = dir_down_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      d_d          = d_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d        = in_sample;
               coef_d     = lfo_q;
               byp_d      = bypass;
               k_d        = '0;
               in_ready_d = 1'b0;
               state_d    = ST_RUN;
               // LFO advances after the current value has been latched into coef.
               if (!dir_down_q) begin
                  if (lfo_up >= MAX_EXT) begin
                     lfo_d      = COEF_MAX;
                     dir_down_d = 1'b1;
                  end else begin
                     lfo_d = Q15_W'(lfo_up);
                  end
               end else begin
                  if (lfo_dn <= MIN_EXT) begin
                     lfo_d      = COEF_MIN;
                     dir_down_d = 1'b0;
                  end else begin
                     lfo_d = Q15_W'(lfo_dn);
                  end
               end
            end
         end

         ST_RUN: begin
            // Bypass keeps x holding the captured sample and leaves d[] untouched.
            if (!byp_q) begin
               d_d[k_q] = alu_d_next;
               x_d      = alu_y;
            end
            if (k_q == K_LAST) begin
               out_sample_d = byp_q ? x_q : alu_y;
               out_valid_d  = 1'b1;
               k_d          = '0;
               state_d      = ST_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         x_q          <= '0;
         coef_q       <= '0;
         byp_q        <= 1'b0;
         lfo_q        <= COEF_MIN;
         dir_down_q   <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         for (int i = 0; i < N_STAGES; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         x_q          <= x_d;
         coef_q       <= coef_d;
         byp_q        <= byp_d;
         lfo_q        <= lfo_d;
         dir_down_q   <= dir_down_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         d_q          <= d_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign lfo_coef   = lfo_q;

endmodule
`default_nettype wire

// File: tb/tb_phaser_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phaser_scheduler
//  Purpose  : Self-checking bench for phaser_scheduler. Five instances with
//             different parameter sets are driven independently; expected
//             outputs come from a sample-level behavioural model.
//             Honours PHASER_SAT_EN for the stage-sum behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phaser_scheduler;

   localparam int NI = 5;
   // 0: default params, 1: pure delay chain, 2: N=1 coef 0.5,
   // 3: LFO sweep 0..100 step 40, 4: N=1 coef -1.0
   localparam int NS   [NI] = '{4, 4, 1, 4, 1};
   localparam int CMIN [NI] = '{0, 0, 16384, 0, -32768};
   localparam int CMAX [NI] = '{26214, 0, 16384, 100, -32768};
   localparam int STP  [NI] = '{64, 0, 0, 40, 0};

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid   [NI];
   logic        in_ready   [NI];
   logic [15:0] in_sample  [NI];
   logic        bypass     [NI];
   logic        out_valid  [NI];
   logic        out_ready  [NI];
   logic [15:0] out_sample [NI];
   logic [15:0] lfo_coef   [NI];

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int md   [NI][16];
   int mlfo [NI];
   bit mup  [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      phaser_scheduler #(
         .N_STAGES (NS[g]),
         .COEF_MIN (16'(CMIN[g])),
         .COEF_MAX (16'(CMAX[g])),
         .LFO_STEP (16'(STP[g]))
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .in_sample  (in_sample[g]),
         .bypass     (bypass[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .out_sample (out_sample[g]),
         .lfo_coef   (lfo_coef[g])
      );
   end

   function automatic int wrap16(input int v);
      int t;
      t = v & 65535;
      return (t >= 32768) ? t - 65536 : t;
   endfunction

   function automatic int fix16(input int v);
`ifdef PHASER_SAT_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
`else
      return wrap16(v);
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NI; i++) begin
         mlfo[i] = CMIN[i];
         mup[i]  = 1'b1;
         for (int k = 0; k < 16; k++) md[i][k] = 0;
      end
   endfunction

   // Triangle sweep between CMIN and CMAX, clamped at the turn points.
   function automatic void model_lfo(input int idx);
      int nx;
      if (mup[idx]) begin
         nx = mlfo[idx] + STP[idx];
         if (nx >= CMAX[idx]) begin nx = CMAX[idx]; mup[idx] = 1'b0; end
      end else begin
         nx = mlfo[idx] - STP[idx];
         if (nx <= CMIN[idx]) begin nx = CMIN[idx]; mup[idx] = 1'b1; end
      end
      mlfo[idx] = nx;
   endfunction

   // Whole-sample allpass cascade.
   function automatic int model_sample(input int idx, input int s, input bit byp, input int coef);
      int x, y, fb, dn;
      x = s;
      for (int k = 0; k < NS[idx]; k++) begin
         fb = wrap16((coef * md[idx][k]) >>> 15);
         y  = fix16(md[idx][k] - fb);
         dn = fix16(x + fb);
         if (!byp) md[idx][k] = dn;
         x = y;
      end
      return byp ? s : x;
   endfunction

   // Push one sample through instance idx and check coefficient, latency, value, release.
   task automatic run_sample(input int idx, input int s, input bit byp, output int got);
      int exp_v, coef, cyc;
      cyc = 0;
      while (in_ready[idx] !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (in_ready[idx] !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait inst=%0d in_ready=%b required=1", idx, in_ready[idx]);
      end
      checks++;
      if (lfo_coef[idx] !== 16'(mlfo[idx])) begin
         errors++;
         $display("FAIL lfo_coef inst=%0d got=%0d required=%0d", idx, $signed(lfo_coef[idx]), mlfo[idx]);
      end
      in_valid[idx]  = 1'b1;
      in_sample[idx] = 16'(s);
      bypass[idx]    = byp;
      coef  = mlfo[idx];
      model_lfo(idx);
      exp_v = model_sample(idx, s, byp, coef);
      @(negedge clk);
      in_valid[idx] = 1'b0;
      bypass[idx]   = 1'b0;
      cyc = 0;
      while (out_valid[idx] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != NS[idx]) begin
         errors++;
         $display("FAIL latency inst=%0d got=%0d cycles required=%0d", idx, cyc, NS[idx]);
      end
      checks++;
      if (out_sample[idx] !== 16'(exp_v)) begin
         errors++;
         $display("FAIL out_sample inst=%0d in=%0d byp=%0b got=%0d required=%0d",
                  idx, s, byp, $signed(out_sample[idx]), exp_v);
      end
      got = $signed(out_sample[idx]);
      if (out_ready[idx] === 1'b1) begin
         @(negedge clk);
         checks++;
         if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL release inst=%0d out_valid=%b in_ready=%b required 0/1",
                     idx, out_valid[idx], in_ready[idx]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1) begin errors++; $display("FAIL rst_in_ready inst=%0d got=%b required=1", i, in_ready[i]); end
         checks++;
         if (out_valid[i] !== 1'b0) begin errors++; $display("FAIL rst_out_valid inst=%0d got=%b required=0", i, out_valid[i]); end
         checks++;
         if (out_sample[i] !== 16'd0) begin errors++; $display("FAIL rst_out_sample inst=%0d got=%0d required=0", i, $signed(out_sample[i])); end
         checks++;
         if (lfo_coef[i] !== 16'(CMIN[i])) begin errors++; $display("FAIL rst_lfo inst=%0d got=%0d required=%0d", i, $signed(lfo_coef[i]), CMIN[i]); end
      end
      reset = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_impulse();
      int ins  [6] = '{1000, 0, 0, 0, 0, 0};
      int outs [6] = '{0, 0, 0, 0, 1000, 0};
      int got;
      for (int n = 0; n < 6; n++) begin
         run_sample(1, ins[n], 1'b0, got);
         checks++;
         if (got != outs[n]) begin errors++; $display("FAIL impulse n=%0d got=%0d required=%0d", n, got, outs[n]); end
      end
   endtask

   task automatic test_halving();
      int ins  [4] = '{16384, 0, 0, 0};
      int outs [4] = '{0, 8192, 4096, 2048};
      int got;
      for (int n = 0; n < 4; n++) begin
         run_sample(2, ins[n], 1'b0, got);
         checks++;
         if (got != outs[n]) begin errors++; $display("FAIL halving n=%0d got=%0d required=%0d", n, got, outs[n]); end
      end
   endtask

   task automatic test_lfo_sweep();
      int seq [8] = '{0, 40, 80, 100, 60, 20, 0, 40};
      int got;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checks++;
         if (lfo_coef[3] !== 16'(seq[n])) begin
            errors++;
            $display("FAIL lfo_sweep n=%0d got=%0d required=%0d", n, $signed(lfo_coef[3]), seq[n]);
         end
         run_sample(3, $urandom_range(0, 2000), 1'b0, got);
      end
   endtask

   task automatic test_saturation();
      int got;
      int exp2;
`ifdef PHASER_SAT_EN
      exp2 = 32767;
`else
      exp2 = -25536;
`endif
      run_sample(4, 20000, 1'b0, got);
      checks++;
      if (got != 0) begin errors++; $display("FAIL sat_first got=%0d required=0", got); end
      run_sample(4, 0, 1'b0, got);
      checks++;
      if (got != exp2) begin errors++; $display("FAIL sat_second got=%0d required=%0d", got, exp2); end
   endtask

   task automatic test_random();
      int got;
      for (int n = 0; n < 40; n++) begin
         run_sample(0, int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 3) == 0), got);
      end
   endtask

   task automatic test_backpressure();
      int got;
      out_ready[0] = 1'b0;
      run_sample(0, int'($urandom_range(0, 65535)) - 32768, 1'b0, got);
      in_valid[0]  = 1'b1;
      in_sample[0] = 16'h1234;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_sample[0] !== 16'(got)) begin
            errors++;
            $display("FAIL hold n=%0d out_valid=%b in_ready=%b out=%0d required 1/0/%0d",
                     n, out_valid[0], in_ready[0], $signed(out_sample[0]), got);
         end
      end
      in_valid[0] = 1'b0;
      checks++;
      if (lfo_coef[0] !== 16'(mlfo[0])) begin
         errors++;
         $display("FAIL hold_lfo got=%0d required=%0d", $signed(lfo_coef[0]), mlfo[0]);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready=%b out_valid=%b required 1/0", in_ready[0], out_valid[0]);
      end
      run_sample(0, 4321, 1'b0, got);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      in_valid[1]  = 1'b1;
      in_sample[1] = 16'd1000;
      bypass[1]    = 1'b0;
      @(negedge clk);
      in_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL midrst_hs in_ready=%b out_valid=%b required 1/0", in_ready[1], out_valid[1]);
      end
      checks++;
      if (lfo_coef[0] !== 16'(CMIN[0])) begin
         errors++;
         $display("FAIL midrst_lfo0 got=%0d required=%0d", $signed(lfo_coef[0]), CMIN[0]);
      end
      checks++;
      if (lfo_coef[3] !== 16'(CMIN[3])) begin
         errors++;
         $display("FAIL midrst_lfo3 got=%0d required=%0d", $signed(lfo_coef[3]), CMIN[3]);
      end
      model_reset();
      test_impulse();
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         in_sample[i] = '0;
         bypass[i]    = 1'b0;
         out_ready[i] = 1'b1;
      end
      @(negedge clk);
      test_reset();
      test_impulse();
      test_halving();
      test_lfo_sweep();
      test_saturation();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
